// File: rtl/hello_world_pio_pkg.sv
// hello_world_pio_pkg: register map and bus width shared by the hello_world PIO blocks
package hello_world_pio_pkg;
  localparam int AV_DW = 32;
  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_BLINK  = 2'd1,
    ADDR_OUTSET = 2'd2,
    ADDR_OUTCLR = 2'd3
  } pio_addr_e;
endpackage

// File: rtl/hello_world_led_pio_if.sv
// hello_world_led_pio_if: Avalon-MM slave port of the LED PIO
interface hello_world_led_pio_if;
  import hello_world_pio_pkg::*;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [AV_DW-1:0] writedata;
  logic [AV_DW-1:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hello_world_blink_timer.sv
// hello_world_blink_timer: prescaler that toggles phase_o every DIV clock cycles
module hello_world_blink_timer #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic phase_o
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d, wrap;
  assign wrap    = cnt_q == CW'(DIV - 1);
  assign phase_o = phase_q;
  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    phase_d = phase_q ^ wrap;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/hello_world_led_pio.sv
// hello_world_led_pio: Avalon-MM LED output PIO with set/clear aliases and blink mask
module hello_world_led_pio
  import hello_world_pio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hello_world_led_pio_if.slave  bus,
  output logic [WIDTH-1:0]      out_port
);
  logic [WIDTH-1:0] data_q, data_d, blink_q, blink_d, out_d, wd;
  logic [AV_DW-1:0] rd_d;
  logic             wr, phase;
  pio_addr_e        addr;
  hello_world_blink_timer #(.DIV(BLINK_DIV)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .phase_o (phase)
  );
  assign addr = pio_addr_e'(bus.address);
  assign wr   = bus.chipselect && !bus.write_n;
  assign wd   = bus.writedata[WIDTH-1:0];
  // read mux samples pre-write state, so a same-cycle read sees the old value
  always_comb begin
    data_d  = !wr                ? data_q :
              addr == ADDR_DATA   ? wd :
              addr == ADDR_OUTSET ? data_q | wd :
              addr == ADDR_OUTCLR ? data_q & ~wd : data_q;
    blink_d = (wr && addr == ADDR_BLINK) ? wd : blink_q;
    rd_d    = addr == ADDR_DATA  ? AV_DW'(data_q) :
              addr == ADDR_BLINK ? AV_DW'(blink_q) : '0;
    out_d   = data_q ^ (blink_q & {WIDTH{phase}});
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q       <= RESET_VAL;
      blink_q      <= '0;
      bus.readdata <= '0;
      out_port     <= RESET_VAL;
    end else begin
      data_q       <= data_d;
      blink_q      <= blink_d;
      bus.readdata <= rd_d;
      out_port     <= out_d;
    end
  end
endmodule

// File: tb/tb_hello_world_led_pio.sv
// tb_hello_world_led_pio: random and directed checks of the LED PIO against a cycle-count model
module tb_hello_world_led_pio;
  localparam int         DIV = 4;
  localparam logic [7:0] RV  = 8'h00;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] out_port;
  int         vectors = 0;
  int         miscompares = 0;
  hello_world_led_pio_if bus ();
  hello_world_led_pio #(.WIDTH(8), .RESET_VAL(RV), .BLINK_DIV(DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );
  always #5 clk = ~clk;
  // model: phase derived from edges elapsed since reset
  logic [7:0]  m_data, m_blink, exp_out;
  logic [31:0] exp_rd;
  int          m_n;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data  <= RV;
      m_blink <= 8'h00;
      m_n     <= 0;
      exp_rd  <= 32'h0;
      exp_out <= RV;
    end else begin
      exp_rd  <= bus.address == 2'd0 ? {24'h0, m_data} :
                 bus.address == 2'd1 ? {24'h0, m_blink} : 32'h0;
      exp_out <= m_data ^ (((m_n / DIV) % 2 == 1) ? m_blink : 8'h00);
      if (bus.chipselect && !bus.write_n)
        case (bus.address)
          2'd0: m_data  <= bus.writedata[7:0];
          2'd1: m_blink <= bus.writedata[7:0];
          2'd2: m_data  <= m_data | bus.writedata[7:0];
          default: m_data <= m_data & ~bus.writedata[7:0];
        endcase
      m_n <= m_n + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    @(negedge clk);
    chk("rd", bus.readdata, exp_rd);
    chk("out", {24'h0, out_port}, {24'h0, exp_out});
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out", {24'h0, out_port}, {24'h0, RV});
    chk("rst_rd", bus.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  logic [7:0] old;
  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    reset_n        = 1'b0;
    repeat (2) @(negedge clk);
    chk("por_out", {24'h0, out_port}, {24'h0, RV});
    reset_n = 1'b1;
    step(2'd0, 1'b0, 1'b1, 0);
    chk("por_rd", bus.readdata, {24'h0, RV});
    step(2'd0, 1'b1, 1'b0, 32'hA5);
    step(2'd0, 1'b0, 1'b1, 0);
    chk("wr_out", {24'h0, out_port}, 32'hA5);
    chk("wr_rd", bus.readdata, 32'hA5);
    step(2'd0, 1'b1, 1'b0, 32'h0F);
    step(2'd2, 1'b1, 1'b0, 32'h30);
    step(2'd0, 1'b0, 1'b1, 0);
    chk("set", bus.readdata, 32'h3F);
    step(2'd3, 1'b1, 1'b0, 32'h05);
    step(2'd0, 1'b0, 1'b1, 0);
    chk("clr", bus.readdata, 32'h3A);
    step(2'd2, 1'b1, 1'b0, 32'h0);
    chk("rd_set", bus.readdata, 32'h0);
    step(2'd3, 1'b1, 1'b0, 32'h0);
    chk("rd_clr", bus.readdata, 32'h0);
    step(2'd0, 1'b0, 1'b1, 0);
    chk("zero_wd", bus.readdata, 32'h3A);
    step(2'd0, 1'b1, 1'b0, 32'h00);
    step(2'd1, 1'b1, 1'b0, 32'h81);
    repeat (20) step(2'd1, 1'b0, 1'b1, 0);
    step(2'd1, 1'b1, 1'b0, 32'h00);
    repeat (2) step(2'd0, 1'b0, 1'b1, 0);
    chk("blink_off", {24'h0, out_port}, 32'h0);
    step(2'd0, 1'b1, 1'b0, 32'hFFFFFF00);
    step(2'd0, 1'b0, 1'b1, 0);
    chk("mask", bus.readdata, 32'h0);
    step(2'd1, 1'b1, 1'b0, 32'hFF);
    step(2'd0, 1'b1, 1'b0, 32'h5A);
    while (m_n % 8 != 3) step(2'd0, 1'b0, 1'b1, 0);
    old = m_data;
    step(2'd0, 1'b1, 1'b0, 32'h3C);
    chk("coll_rd", bus.readdata, {24'h0, old});
    step(2'd0, 1'b0, 1'b1, 0);
    chk("coll_out", {24'h0, out_port}, 32'hC3);
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    step(2'd1, 1'b1, 1'b0, 32'hFF);
    step(2'd0, 1'b1, 1'b0, 32'h77);
    repeat (3) step(2'd0, 1'b0, 1'b1, 0);
    do_reset();
    step(2'd0, 1'b0, 1'b1, 0);
    chk("post_rst_rd", bus.readdata, {24'h0, RV});
    repeat (10) step(2'd1, 1'b0, 1'b1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
